demux_router: RTL

Parametrised 1-to-N registered demultiplexer with valid/ready flow control on every port. It steers a DATA_W-bit word from one upstream source to one selected output channel, or to all channels in broadcast mode. Each channel holds the word in a one-entry holding register until its consumer accepts it. It sits between the receive datapath and the per-channel consumers, and replaces fixed-width demux arrays that had no flow control.

---
 rtl/demux_router.sv | 87 ++++++++
 1 files changed

// File: rtl/demux_router.sv
// 1-to-N registered demultiplexer with valid/ready flow control on every port.
// Each channel owns a one-entry holding register; broadcast writes all channels or none.
module demux_router #(
    parameter int DATA_W = 4,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic [DATA_W-1:0]        inData,
    input  logic [SEL_W-1:0]         inSel,
    input  logic                     inBcast,
    input  logic                     inValid,
    output logic                     outReady,
    output logic [N_CH*DATA_W-1:0]   outData,
    output logic [N_CH-1:0]          outValid,
    input  logic [N_CH-1:0]          inReady,
    output logic                     outSelErr
);

    localparam logic [SEL_W:0] LP_NCH = (SEL_W+1)'(N_CH);

    logic [DATA_W-1:0] r_data [N_CH];
    logic [N_CH-1:0]   r_valid;
    logic              r_sel_err;

    logic [N_CH-1:0]   w_drain;
    logic [N_CH-1:0]   w_free;
    logic [N_CH-1:0]   w_uni_hit;
    logic [N_CH-1:0]   w_load;
    logic              w_sel_ok;
    logic              w_accept;

    assign w_drain  = r_valid & inReady;
    assign w_free   = ~r_valid | w_drain;
    assign w_sel_ok = ({1'b0, inSel} < LP_NCH);

    // One-hot of the addressed channel; all zero when inSel is out of range.
    always_comb begin
        w_uni_hit = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_uni_hit[k] = ({1'b0, inSel} == (SEL_W+1)'(k));
        end
    end

    always_comb begin
        outReady = 1'b1;
        if (inBcast) begin
            outReady = &w_free;
        end else if (w_sel_ok) begin
            outReady = |(w_free & w_uni_hit);
        end
    end

    assign w_accept = inValid & outReady;
    assign w_load   = (inBcast ? {N_CH{1'b1}} : w_uni_hit) & {N_CH{w_accept}};

    // A load in the same cycle as a drain keeps the flag set: no bubble.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_valid   <= '0;
            r_sel_err <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid   <= w_load | (r_valid & ~w_drain);
            r_sel_err <= w_accept & ~inBcast & ~w_sel_ok;
            for (int k = 0; k < N_CH; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= inData;
                end
            end
        end
    end

    always_comb begin
        outData = '0;
        for (int k = 0; k < N_CH; k++) begin
            outData[k*DATA_W +: DATA_W] = r_data[k];
        end
    end

    assign outValid  = r_valid;
    assign outSelErr = r_sel_err;

endmodule
